pe_seq_master: RTL

Bus-initiator sequencer that drives the PE accelerator's SRAM-like word port (A=0, B=1, CTRL=2, RES=3, STATUS=4) from the master side. It takes a job command and a stream of operand pairs, then issues one write sequence per pair: A, B, then CTRL start. It polls STATUS until the valid bit is set, reads RES after the last pair, and returns the 32-bit result on a valid/ready output. It sits between a host-side command/operand source and the PE slave, replacing software polling.

---
 rtl/pe_seq_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pe_seq_master.sv
// pe_seq_master: bus-initiator sequencer for the PE accelerator word port.
//
// Accepts a job (length, mode, optional accumulator clear). For each operand
// pair it writes A, B and a CTRL start. It then polls STATUS until bit0 is
// set or the poll budget runs out. After the last pair it reads RES and
// presents it on a valid/ready result port.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   cmd_*                    job command (valid/ready, len, mode, clear)
//   op_*                     operand stream (A unsigned, B signed)
//   res_*                    result word + timeout error flag (valid/ready)
//   busy_o                   high whenever not idle
//   req_o/wen_o/addr_o/wdata_o/rdata_i
//                            PE SRAM-like word port. rdata_i arrives one
//                            cycle after a read address.
module pe_seq_master #(
  parameter int ADDR_W       = 3,
  parameter int CNT_W        = 16,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_len_i,
  input  logic              cmd_mode_i,
  input  logic              cmd_clear_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [7:0]        op_a_i,
  input  logic [7:0]        op_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [31:0]       res_data_o,
  output logic              res_err_o,
  output logic              busy_o,
  output logic              req_o,
  output logic [3:0]        wen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i
);

  localparam int PC_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PC_W-1:0] POLL_MAX = PC_W'(POLL_TIMEOUT);

  localparam logic [ADDR_W-1:0] ADDR_A      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_B      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_RES    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(4);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_WR_A, S_WR_B, S_WR_CTRL, S_SETTLE,
    S_POLL_REQ, S_POLL_CHK, S_RD_RES, S_RD_CAP, S_RESULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pair_cnt;
  logic [PC_W-1:0]  poll_cnt;
  logic [7:0]       b_lat;
  logic             mode_q;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pair_cnt   <= '0;
      poll_cnt   <= '0;
      b_lat      <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      res_data_o <= '0;
      res_err_o  <= 1'b0;
    end else begin
      // Poll budget runs from the start write. It counts every cycle from
      // SETTLE onward and saturates, so the check never wraps.
      if (state == S_WR_CTRL)
        poll_cnt <= '0;
      else if ((state == S_SETTLE || state == S_POLL_REQ || state == S_POLL_CHK)
               && poll_cnt != POLL_MAX)
        poll_cnt <= poll_cnt + 1'b1;

      case (state)
        S_IDLE: if (cmd_valid_i) begin
          pair_cnt <= cmd_len_i;
          mode_q   <= cmd_mode_i;
          if (cmd_clear_i)              state <= S_CLEAR;
          else if (cmd_len_i != '0)     state <= S_WR_A;
          else                          state <= S_RD_RES;
        end
        S_CLEAR:   state <= (pair_cnt != '0) ? S_WR_A : S_RD_RES;
        S_WR_A: if (op_valid_i) begin
          b_lat <= op_b_i;
          state <= S_WR_B;
        end
        S_WR_B:     state <= S_WR_CTRL;
        S_WR_CTRL:  state <= S_SETTLE;
        // Gap before the first STATUS read: the start pulse must have
        // dropped the slave's sticky valid bit.
        S_SETTLE:   state <= S_POLL_REQ;
        S_POLL_REQ: state <= S_POLL_CHK;
        S_POLL_CHK: begin
          if (rdata_i[0]) begin
            pair_cnt <= pair_cnt - 1'b1;
            state    <= (pair_cnt != CNT_W'(1)) ? S_WR_A : S_RD_RES;
          end else if (poll_cnt < POLL_MAX) begin
            state <= S_POLL_REQ;
          end else begin
            // Abort. The remaining operands are left for upstream to flush.
            err_q <= 1'b1;
            state <= S_RD_RES;
          end
        end
        S_RD_RES:   state <= S_RD_CAP;
        S_RD_CAP: begin
          res_data_o <= rdata_i;
          res_err_o  <= err_q;
          state      <= S_RESULT;
        end
        S_RESULT: if (res_ready_i) begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode the state register only. No input reaches them.
  assign cmd_ready_o = (state == S_IDLE);
  assign op_ready_o  = (state == S_WR_A);
  assign res_valid_o = (state == S_RESULT);
  assign busy_o      = (state != S_IDLE);

  // Bus drive. Idle cycles return every bus field to zero.
  always_comb begin
    req_o   = 1'b0;
    wen_o   = 4'b0000;
    addr_o  = '0;
    wdata_o = '0;
    case (state)
      S_CLEAR: begin
        req_o   = 1'b1;
        wen_o   = 4'b1111;
        addr_o  = ADDR_CTRL;
        wdata_o = {29'b0, 1'b1, mode_q, 1'b0};
      end
      S_WR_A: if (op_valid_i) begin
        req_o   = 1'b1;
        wen_o   = 4'b1111;
        addr_o  = ADDR_A;
        wdata_o = {24'b0, op_a_i};
      end
      S_WR_B: begin
        req_o   = 1'b1;
        wen_o   = 4'b1111;
        addr_o  = ADDR_B;
        wdata_o = {24'b0, b_lat};
      end
      S_WR_CTRL: begin
        req_o   = 1'b1;
        wen_o   = 4'b1111;
        addr_o  = ADDR_CTRL;
        wdata_o = {30'b0, mode_q, 1'b1};
      end
      S_POLL_REQ: begin
        req_o  = 1'b1;
        addr_o = ADDR_STATUS;
      end
      S_RD_RES: begin
        req_o  = 1'b1;
        addr_o = ADDR_RES;
      end
      default: ;
    endcase
  end

endmodule
